fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

Program-counter register and instruction-fetch sequencer for the single-issue core. Holds the current PC, computes the sequential successor through the `pc_adder` stage (PC + 4), and selects between that and a redirect target from execute. Issues one instruction-memory request at a time, and presents each fetched instruction with its PC to decode over a valid/ready handshake.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `redirect_valid`  in  1  execute requests a PC change (branch/jump taken).
- `redirect_target`  in  32  new PC; bits [1:0] forced to 0 on load.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  fetch address (current PC).
- `imem_gnt`  in  1  memory accepts request this cycle.
- `imem_rvalid`  in  1  response data valid.
- `imem_rdata`  in  32  instruction word.
- `if_valid`  out  1  fetched instruction available to decode.
- `if_pc`  out  32  PC of presented instruction.
- `if_instr`  out  32  presented instruction word.
- `if_ready`  in  1  decode accepts the presented instruction.

## Operation
- States: IDLE, REQ, WAIT, HOLD. Reset state IDLE; IDLE -> REQ unconditionally next cycle.
- REQ: `imem_req`=1, `imem_addr`=pc. On `imem_gnt` -> WAIT. Without grant, stay in REQ; addr stays stable unless a redirect occurs.
- WAIT: on `imem_rvalid`, capture `imem_rdata` into `if_instr` and pc into `if_pc`, -> HOLD. If the kill flag is set, discard the data, clear kill, -> REQ.
- HOLD: `if_valid`=1. On `if_ready`: pc <= pc_next (pc+4 via `pc_adder`), -> REQ.
- Redirect has priority over all sequential updates, in every state except IDLE:
  - REQ without gnt: pc <= target; stay REQ.
  - REQ with gnt, or WAIT: pc <= target; set kill; -> WAIT. The in-flight response is dropped.
  - HOLD: pc <= target; `if_valid` drops next cycle, even if `if_ready` was high in the same cycle; -> REQ.
- Exactly one request outstanding at any time. `imem_req` is never asserted in WAIT or HOLD.
- Arithmetic is modulo 2^32: pc 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.

## Timing
- Reset values: pc=`RESET_PC`, state IDLE, `imem_req`=0, `if_valid`=0, `if_pc`=0, `if_instr`=0, kill=0.
- `imem_req`/`imem_addr` are combinational from the state and pc registers. `if_valid`/`if_pc`/`if_instr` are registered.
- Minimum latency: request cycle N (gnt same cycle), rvalid N+1, `if_valid` N+2. Next request at the earliest N+3, if `if_ready` is high in N+2.
- `if_pc`/`if_instr` hold stable while `if_valid`=1 and `if_ready`=0.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). A late `imem_rvalid` arriving in IDLE/REQ is ignored.

## Structure
- A shared package `cpu_pkg` holds the fetch state enum, `XLEN`=32, `INSTR_BYTES`=4, and the NOP encoding 32'h0000_0013.
- One sub-module instance: the existing `pc_adder` (pc -> pc+4). No other sub-modules.

## Test plan
- Reset release, memory always grants with 1-cycle rvalid, `if_ready`=1 -> `if_pc` sequence 0x0, 0x4, 0x8, with `imem_req` never high while `if_valid`=1.
- `imem_gnt` held low for 3 cycles -> `imem_req`=1 and `imem_addr`=0x0 stable for all 4 cycles; fetch completes normally.
- `if_ready`=0 for 5 cycles in HOLD with instr 0xDEADBEEF at PC 0x8 -> outputs stable; after acceptance, next `imem_addr`=0xC.
- Redirect to 0x100 while in WAIT for PC 0x4 -> the response for 0x4 never appears on `if_*`; next request `imem_addr`=0x100; `if_pc`=0x100. Redirect target 0x203 -> fetch address 0x200.
- PC 0xFFFF_FFFC accepted -> next `imem_addr`=0x0000_0000.
- `rst_n` pulsed low during WAIT with `RESET_PC`=0x8000_0000 -> `if_valid`=0 immediately; first request after release is at 0x8000_0000; the stale rvalid is ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
//------------------------------------------------------------------------------
// Module   : cpu_pkg
// Purpose  : Shared core constants and the fetch sequencer state encoding.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // Fetch sequencer states, kept as explicit-width constants for legacy tools
    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t FETCH_IDLE = 2'd0;
    localparam fetch_state_t FETCH_REQ  = 2'd1;
    localparam fetch_state_t FETCH_WAIT = 2'd2;
    localparam fetch_state_t FETCH_HOLD = 2'd3;

endpackage

`default_nettype wire

// File: rtl/pc_adder.sv
//------------------------------------------------------------------------------
// Module   : pc_adder
// Purpose  : Sequential program-counter successor (pc + instruction size).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_adder
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next
);

    localparam logic [XLEN-1:0] C_STEP = XLEN'(INSTR_BYTES);

    // Wraps modulo 2^XLEN with no carry out.
    assign pc_next = pc + C_STEP;

endmodule

`default_nettype wire

// File: rtl/fetch_pc_unit.sv
//------------------------------------------------------------------------------
// Module   : fetch_pc_unit
// Purpose  : PC register and single-outstanding instruction-fetch sequencer
//            with redirect handling and a valid/ready output to decode.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_pc_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_ready
);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_if_pc;
    logic [XLEN-1:0] r_if_instr;
    logic            r_if_valid;
    logic            r_kill;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_target;

    assign w_target = redirect_target & 32'hFFFF_FFFC;

    pc_adder u_pc_adder (
        .pc      (r_pc),
        .pc_next (w_pc_next)
    );

    assign imem_req  = (r_state == FETCH_REQ);
    assign imem_addr = r_pc;
    assign if_valid  = r_if_valid;
    assign if_pc     = r_if_pc;
    assign if_instr  = r_if_instr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FETCH_IDLE;
            r_pc       <= RESET_PC;
            r_kill     <= 1'b0;
            r_if_valid <= 1'b0;
            r_if_pc    <= '0;
            r_if_instr <= '0;
        end else begin
            case (r_state)
                FETCH_IDLE: begin
                    r_state <= FETCH_REQ;
                end
                FETCH_REQ: begin
                    if (redirect_valid) begin
                        r_pc <= w_target;
                    end
                    // A granted request redirected in the same cycle must still drain
                    if (imem_gnt) begin
                        r_state <= FETCH_WAIT;
                        r_kill  <= redirect_valid;
                    end
                end
                FETCH_WAIT: begin
                    if (redirect_valid) begin
                        r_pc <= w_target;
                        // Response arriving with the redirect is the one being dropped
                        if (imem_rvalid) begin
                            r_kill  <= 1'b0;
                            r_state <= FETCH_REQ;
                        end else begin
                            r_kill  <= 1'b1;
                        end
                    end else if (imem_rvalid) begin
                        if (r_kill) begin
                            r_kill  <= 1'b0;
                            r_state <= FETCH_REQ;
                        end else begin
                            r_if_valid <= 1'b1;
                            r_if_pc    <= r_pc;
                            r_if_instr <= imem_rdata;
                            r_state    <= FETCH_HOLD;
                        end
                    end
                end
                FETCH_HOLD: begin
                    if (redirect_valid) begin
                        r_pc       <= w_target;
                        r_if_valid <= 1'b0;
                        r_state    <= FETCH_REQ;
                    end else if (if_ready) begin
                        r_pc       <= w_pc_next;
                        r_if_valid <= 1'b0;
                        r_state    <= FETCH_REQ;
                    end
                end
                default: begin
                    r_state <= FETCH_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_fetch_pc_unit
// Purpose  : Directed self-checking bench for fetch_pc_unit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_ready;

    logic        imem_req,  hi_imem_req;
    logic [31:0] imem_addr, hi_imem_addr;
    logic        if_valid,  hi_if_valid;
    logic [31:0] if_pc,     hi_if_pc;
    logic [31:0] if_instr,  hi_if_instr;

    int errors = 0;
    int checks = 0;
    int overlap = 0;

    fetch_pc_unit dut (
        .clk (clk), .rst_n (rst_n),
        .redirect_valid (redirect_valid), .redirect_target (redirect_target),
        .imem_req (imem_req), .imem_addr (imem_addr), .imem_gnt (imem_gnt),
        .imem_rvalid (imem_rvalid), .imem_rdata (imem_rdata),
        .if_valid (if_valid), .if_pc (if_pc), .if_instr (if_instr),
        .if_ready (if_ready)
    );

    // Lock-stepped twin with a non-zero reset vector
    fetch_pc_unit #(.RESET_PC (32'h8000_0000)) dut_hi (
        .clk (clk), .rst_n (rst_n),
        .redirect_valid (redirect_valid), .redirect_target (redirect_target),
        .imem_req (hi_imem_req), .imem_addr (hi_imem_addr), .imem_gnt (imem_gnt),
        .imem_rvalid (imem_rvalid), .imem_rdata (imem_rdata),
        .if_valid (hi_if_valid), .if_pc (hi_if_pc), .if_instr (hi_if_instr),
        .if_ready (if_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && imem_req && if_valid) overlap++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        check_eq("req_timeout", {31'd0, imem_req}, 32'd1);
    endtask

    // One complete fetch: optional grant stall and decode back-pressure
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data,
                            input int gnt_delay, input int hold);
        wait_req();
        for (int i = 0; i < gnt_delay; i++) begin
            check_eq("stall_req", {31'd0, imem_req}, 32'd1);
            check_eq("stall_addr", imem_addr, addr);
            tick();
        end
        check_eq("req_addr", imem_addr, addr);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        check_eq("wait_noreq", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        check_eq("if_valid", {31'd0, if_valid}, 32'd1);
        check_eq("if_pc", if_pc, addr);
        check_eq("if_instr", if_instr, data);
        for (int i = 0; i < hold; i++) begin
            tick();
            check_eq("hold_valid", {31'd0, if_valid}, 32'd1);
            check_eq("hold_pc", if_pc, addr);
            check_eq("hold_instr", if_instr, data);
            check_eq("hold_noreq", {31'd0, imem_req}, 32'd0);
        end
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;
        check_eq("accept_drop", {31'd0, if_valid}, 32'd0);
        check_eq("next_req", {31'd0, imem_req}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        if_ready = 1'b0;
        tick();
        tick();
        check_eq("rst_req", {31'd0, imem_req}, 32'd0);
        check_eq("rst_valid", {31'd0, if_valid}, 32'd0);
        check_eq("rst_if_pc", if_pc, 32'h0);
        check_eq("rst_if_instr", if_instr, 32'h0);
        check_eq("rst_addr", imem_addr, 32'h0);
        check_eq("rst_addr_hi", hi_imem_addr, 32'h8000_0000);
        rst_n = 1'b1;
        tick();
        check_eq("idle_to_req", {31'd0, imem_req}, 32'd1);

        // Sequential stream, back-pressure at 0x8, grant stall at 0xC
        do_fetch(32'h0, 32'h0000_0111, 0, 0);
        do_fetch(32'h4, 32'h0000_0222, 0, 0);
        do_fetch(32'h8, 32'hDEAD_BEEF, 0, 5);
        check_eq("after_hold_addr", imem_addr, 32'hC);
        do_fetch(32'hC, 32'h0000_0333, 3, 0);

        // Redirect while waiting: the response for 0x10 is discarded
        wait_req();
        check_eq("pre_redir_addr", imem_addr, 32'h10);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        redirect_valid = 1'b1;
        redirect_target = 32'h100;
        tick();
        redirect_valid = 1'b0;
        check_eq("killwait_noreq", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0BAD_0BAD;
        tick();
        imem_rvalid = 1'b0;
        check_eq("killed_valid", {31'd0, if_valid}, 32'd0);
        check_eq("redir_req", {31'd0, imem_req}, 32'd1);
        check_eq("redir_addr", imem_addr, 32'h100);
        do_fetch(32'h100, 32'h0000_1234, 0, 0);

        // Redirect in HOLD with if_ready high, unaligned target
        wait_req();
        check_eq("seq_after_redir", imem_addr, 32'h104);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0000_5555;
        tick();
        imem_rvalid = 1'b0;
        check_eq("hold_redir_pre", {31'd0, if_valid}, 32'd1);
        if_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h203;
        tick();
        if_ready = 1'b0;
        redirect_valid = 1'b0;
        check_eq("hold_redir_valid", {31'd0, if_valid}, 32'd0);
        check_eq("hold_redir_req", {31'd0, imem_req}, 32'd1);
        check_eq("align_addr", imem_addr, 32'h200);

        // Redirect in REQ without grant, then wrap at the top of memory
        redirect_valid = 1'b1;
        redirect_target = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        check_eq("req_redir_req", {31'd0, imem_req}, 32'd1);
        check_eq("req_redir_addr", imem_addr, 32'hFFFF_FFFC);
        do_fetch(32'hFFFF_FFFC, 32'h0000_7777, 0, 0);
        check_eq("wrap_addr", imem_addr, 32'h0);

        // Redirect coinciding with grant: the drained response is dropped
        imem_gnt = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h40;
        tick();
        imem_gnt = 1'b0;
        redirect_valid = 1'b0;
        check_eq("gnt_redir_noreq", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0BAD_0001;
        tick();
        imem_rvalid = 1'b0;
        check_eq("gnt_redir_valid", {31'd0, if_valid}, 32'd0);
        check_eq("gnt_redir_addr", imem_addr, 32'h40);

        // Asynchronous reset during WAIT, stale rvalid afterwards
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", {31'd0, if_valid}, 32'd0);
        check_eq("arst_if_pc", if_pc, 32'h0);
        check_eq("arst_if_instr", if_instr, 32'h0);
        check_eq("arst_addr_hi", hi_imem_addr, 32'h8000_0000);
        check_eq("arst_req", {31'd0, imem_req}, 32'd0);
        tick();
        rst_n = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0BAD_0002;
        tick();
        tick();
        imem_rvalid = 1'b0;
        check_eq("stale_valid", {31'd0, if_valid}, 32'd0);
        check_eq("stale_valid_hi", {31'd0, hi_if_valid}, 32'd0);
        check_eq("post_rst_req_hi", {31'd0, hi_imem_req}, 32'd1);
        check_eq("post_rst_addr_hi", hi_imem_addr, 32'h8000_0000);
        check_eq("post_rst_addr", imem_addr, 32'h0);
        do_fetch(32'h0, 32'h0000_0999, 0, 0);

        check_eq("req_while_valid", overlap, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
